// File: rtl/md_ctrl_pkg.sv
// Shared definitions for the multiply/divide controller.
//   md_op encodings, FSM state type, counter width and an operation
//   classification helper used by md_ctrl and md_arith.
package md_ctrl_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    // Busy durations are limited to 1..15, so 4 bits cover the counter.
    localparam int CNT_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_t;

    // Multi-cycle operations: those that go through the busy sequence.
    function automatic logic is_long_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath.
//   op          : md_op encoding
//   rs_val      : multiplicand / dividend
//   rt_val      : multiplier / divisor
//   result      : {hi, lo}; product for MULT/MULTU, {remainder, quotient}
//                 for DIV/DIVU
//   div_by_zero : DIV/DIVU with rt_val == 0 (result is then meaningless)
module md_arith
    import md_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] sden;
    logic [31:0] uden;
    logic [31:0] sq_mag;
    logic [31:0] sr_mag;
    logic [31:0] sq;
    logic [31:0] sr;
    logic [31:0] uq;
    logic [31:0] ur;
    logic        rt_zero;

    always_comb begin
        rt_zero = (rt_val == 32'd0);

        // Sign-extend to 64 bits so the truncated 64-bit product is the
        // correct two's-complement signed product.
        prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
        prod_u = {32'd0, rs_val} * {32'd0, rt_val};

        // Signed divide on magnitudes. 0x80000000 has magnitude 0x80000000
        // as an unsigned value, so the overflow case falls out naturally.
        a_mag  = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
        b_mag  = rt_val[31] ? (~rt_val + 32'd1) : rt_val;
        // Substitute 1 for a zero divisor; the result is discarded anyway.
        sden   = rt_zero ? 32'd1 : b_mag;
        uden   = rt_zero ? 32'd1 : rt_val;
        sq_mag = a_mag / sden;
        sr_mag = a_mag % sden;
        sq     = (rs_val[31] ^ rt_val[31]) ? (~sq_mag + 32'd1) : sq_mag;
        sr     = rs_val[31] ? (~sr_mag + 32'd1) : sr_mag;
        uq     = rs_val / uden;
        ur     = rs_val % uden;

        result      = '0;
        div_by_zero = 1'b0;
        case (op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV: begin
                result      = {sr, sq};
                div_by_zero = rt_zero;
            end
            MD_DIVU: begin
                result      = {ur, uq};
                div_by_zero = rt_zero;
            end
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide controller for the E stage: owns HI/LO, sequences
// multi-cycle MULT/MULTU/DIV/DIVU, executes MTHI/MTLO, serves MFHI/MFLO.
//   clk     : system clock, rising edge
//   reset   : asynchronous active-low reset
//   md_op   : E-stage md operation
//   rs_val  : forwarded rs operand
//   rt_val  : forwarded rt operand
//   rd_sel  : read select, 0 = LO, 1 = HI
//   start   : md_op is a multi-cycle op and the block is idle
//   busy    : an operation is in flight (registered)
//   rd_data : committed HI or LO
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO
// ST_BUSY | counting down; result held in pend_* until cnt reaches 1
module md_ctrl
    import md_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        rd_sel,
    output logic        start,
    output logic        busy,
    output logic [31:0] rd_data
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    md_state_t         state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [31:0]       hi, hi_nxt;
    logic [31:0]       lo, lo_nxt;
    logic [31:0]       pend_hi, pend_hi_nxt;
    logic [31:0]       pend_lo, pend_lo_nxt;
    logic              pend_dz, pend_dz_nxt;
    logic              busy_nxt;
    logic [63:0]       arith_result;
    logic              arith_dz;

    md_arith u_arith (
        .op          (md_op),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .result      (arith_result),
        .div_by_zero (arith_dz)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_dz <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            hi      <= hi_nxt;
            lo      <= lo_nxt;
            pend_hi <= pend_hi_nxt;
            pend_lo <= pend_lo_nxt;
            pend_dz <= pend_dz_nxt;
            busy    <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        hi_nxt      = hi;
        lo_nxt      = lo;
        pend_hi_nxt = pend_hi;
        pend_lo_nxt = pend_lo;
        pend_dz_nxt = pend_dz;
        busy_nxt    = busy;
        start       = 1'b0;

        if (state == ST_IDLE) begin
            if (is_long_op(md_op)) begin
                start       = 1'b1;
                pend_hi_nxt = arith_result[63:32];
                pend_lo_nxt = arith_result[31:0];
                pend_dz_nxt = arith_dz;
                cnt_nxt     = ((md_op == MD_MULT) || (md_op == MD_MULTU)) ? MULT_LOAD : DIV_LOAD;
                state_nxt   = ST_BUSY;
                busy_nxt    = 1'b1;
            end else if (md_op == MD_MTHI) begin
                hi_nxt = rs_val;
            end else if (md_op == MD_MTLO) begin
                lo_nxt = rs_val;
            end
        end else begin
            // Any md_op seen here is ignored; the hazard unit keeps it NONE.
            cnt_nxt = cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
                if (!pend_dz) begin
                    hi_nxt = pend_hi;
                    lo_nxt = pend_lo;
                end
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
            end
        end
    end

    assign rd_data = rd_sel ? hi : lo;

endmodule

// File: tb/tb_md_ctrl.sv
module tb_md_ctrl;

    localparam int N_MULT = 5;
    localparam int N_DIV  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        rd_sel = 1'b0;
    logic        start;
    logic        busy;
    logic [31:0] rd_data;

    int total = 0;
    int bad   = 0;

    md_ctrl #(.MULT_CYCLES(N_MULT), .DIV_CYCLES(N_DIV)) dut (
        .clk     (clk),
        .reset   (reset),
        .md_op   (md_op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .rd_sel  (rd_sel),
        .start   (start),
        .busy    (busy),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks cycle numbers: an op accepted at the edge opening cycle c keeps
    // busy through cycle c+N-1 and its result appears at the edge opening c+N.
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi = 32'd0, m_plo = 32'd0;
    bit          m_pdz = 1'b0;
    bit          m_active = 1'b0;
    longint      cyc = 0;
    longint      m_end = 0;

    function automatic void model_compute(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, output logic [63:0] r,
                                          output bit dz);
        longint sa, sb, ua, ub, q, rm;
        logic [63:0] qb, rb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        dz = 1'b0;
        r  = '0;
        case (op)
            3'd1: r = sa * sb;
            3'd2: r = ua * ub;
            3'd3, 3'd4: begin
                if (b == 32'd0) begin
                    dz = 1'b1;
                end else begin
                    if (op == 3'd3) begin
                        q  = sa / sb;
                        rm = sa % sb;
                    end else begin
                        q  = ua / ub;
                        rm = ua % ub;
                    end
                    qb = q;
                    rb = rm;
                    r  = {rb[31:0], qb[31:0]};
                end
            end
            default: r = '0;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        logic [63:0] r;
        bit dz;
        if (!reset) begin
            m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pdz = 0; m_active = 0;
        end else begin
            cyc++;
            if (m_active) begin
                if (cyc == m_end) begin
                    m_active = 0;
                    if (!m_pdz) begin
                        m_hi = m_phi;
                        m_lo = m_plo;
                    end
                end
            end else if (md_op >= 3'd1 && md_op <= 3'd4) begin
                model_compute(md_op, rs_val, rt_val, r, dz);
                m_phi    = r[63:32];
                m_plo    = r[31:0];
                m_pdz    = dz;
                m_active = 1;
                m_end    = cyc + ((md_op <= 3'd2) ? N_MULT : N_DIV);
            end else if (md_op == 3'd5) begin
                m_hi = rs_val;
            end else if (md_op == 3'd6) begin
                m_lo = rs_val;
            end
        end
    end

    // Compare process: all outputs against the model on every falling edge.
    always @(negedge clk) begin
        check("model busy", {31'd0, busy}, {31'd0, m_active});
        check("model start", {31'd0, start},
              {31'd0, (!m_active && md_op >= 3'd1 && md_op <= 3'd4)});
        check("model rd_data", rd_data, rd_sel ? m_hi : m_lo);
    end

    always @(negedge clk) begin
        if (reset && busy)
            assert (md_op == 3'd0 || md_op == 3'd7) else $error("md op issued while busy");
    end

    // ---------------- directed stimulus ----------------
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n_exp, output logic [31:0] mid);
        int n;
        n   = 0;
        mid = 32'd0;
        @(posedge clk);
        #2;
        md_op  = op;
        rs_val = a;
        rt_val = b;
        #1 check({name, " start"}, {31'd0, start}, 32'd1);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #2;
            md_op  = 3'd0;
            rs_val = 32'd0;
            rt_val = 32'd0;
            #1;
            if (i == 2) mid = rd_data;
            if (busy) n++;
            else break;
        end
        check({name, " busy cycles"}, n, n_exp);
    endtask

    task automatic read_chk(input string name, input logic sel, input logic [31:0] exp);
        @(negedge clk);
        #2 rd_sel = sel;
        #1 check(name, rd_data, exp);
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] v);
        @(posedge clk);
        #2;
        md_op  = op;
        rs_val = v;
        #1 check("mt busy", {31'd0, busy}, 32'd0);
    endtask

    logic [31:0] mid;

    initial begin
        #1 reset = 1'b0;
        #2;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset lo", rd_data, 32'd0);
        rd_sel = 1'b1;
        #1 check("reset hi", rd_data, 32'd0);
        rd_sel = 1'b0;
        #19 reset = 1'b1;

        run_op("mult", 3'd1, 32'hFFFFFFFE, 32'd3, 5, mid);
        read_chk("mult hi", 1'b1, 32'hFFFFFFFF);
        read_chk("mult lo", 1'b0, 32'hFFFFFFFA);

        run_op("multu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, mid);
        read_chk("multu hi", 1'b1, 32'hFFFFFFFE);
        read_chk("multu lo", 1'b0, 32'h00000001);

        run_op("div", 3'd3, 32'hFFFFFFF9, 32'd2, 10, mid);
        check("div old lo while busy", mid, 32'h00000001);
        read_chk("div hi", 1'b1, 32'hFFFFFFFF);
        read_chk("div lo", 1'b0, 32'hFFFFFFFD);

        mt(3'd5, 32'h11);
        mt(3'd6, 32'h22);
        run_op("divu0", 3'd4, 32'd100, 32'd0, 10, mid);
        read_chk("divu0 hi", 1'b1, 32'h11);
        read_chk("divu0 lo", 1'b0, 32'h22);

        mt(3'd5, 32'hDEADBEEF);
        mt(3'd6, 32'h12345678);
        mt(3'd0, 32'h0);
        read_chk("mthi", 1'b1, 32'hDEADBEEF);
        read_chk("mtlo", 1'b0, 32'h12345678);

        // Reset in the middle of the third busy cycle of a MULT.
        @(posedge clk);
        #2;
        md_op  = 3'd1;
        rs_val = 32'd5;
        rt_val = 32'd7;
        #1 check("rst mult start", {31'd0, start}, 32'd1);
        @(posedge clk);
        #2 md_op = 3'd0;
        @(posedge clk);
        @(posedge clk);
        #3 check("rst busy before", {31'd0, busy}, 32'd1);
        #1 reset = 1'b0;
        #1;
        check("rst busy after", {31'd0, busy}, 32'd0);
        check("rst lo", rd_data, 32'd0);
        read_chk("rst hi", 1'b1, 32'd0);
        @(posedge clk);
        #4;
        reset  = 1'b1;
        rd_sel = 1'b0;

        run_op("divu after rst", 3'd4, 32'd9, 32'd4, 10, mid);
        read_chk("divu hi", 1'b1, 32'd1);
        read_chk("divu lo", 1'b0, 32'd2);

        run_op("div ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 10, mid);
        read_chk("div ovf hi", 1'b1, 32'd0);
        read_chk("div ovf lo", 1'b0, 32'h80000000);

        repeat (2) @(posedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Multiply/divide controller for the 5-stage MIPS pipeline; sits in the E stage beside the ALU.
- Owns the HI/LO registers and sequences multi-cycle MULT/MULTU/DIV/DIVU.
- Executes MTHI/MTLO writes and serves MFHI/MFLO reads.
- Emits `start` and `busy`; the hazard unit uses them to stall any md-class instruction in D.

Parameters:
- MULT_CYCLES, 5, busy duration for MULT/MULTU (legal range 1..15).
- DIV_CYCLES, 10, busy duration for DIV/DIVU (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- md_op  input  3  E-stage md operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- rs_val  input  32  forwarded E-stage rs operand (dividend / multiplicand / MT source).
- rt_val  input  32  forwarded E-stage rt operand (divisor / multiplier).
- rd_sel  input  1  read select: 0 = LO, 1 = HI.
- start  output  1  combinational; 1 when md_op is in 1..4 and the block is IDLE.
- busy  output  1  registered; 1 while an operation is in flight.
- rd_data  output  32  combinational: rd_sel ? HI : LO.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE, busy = 0, cnt = 0.
  - HI = LO = 0, pending registers = 0.
  - Reset mid-operation aborts the operation; HI and LO read 0 after reset.
- States: IDLE, BUSY.
- IDLE, md_op 1..4 at rising edge T:
  - Compute the 64-bit result from rs_val/rt_val and latch it into pend_hi/pend_lo.
  - Load cnt = MULT_CYCLES or DIV_CYCLES.
  - Go to BUSY; busy = 1 from cycle T+1.
- BUSY:
  - cnt decrements each edge.
  - At the edge where cnt == 1: HI <= pend_hi, LO <= pend_lo, busy <= 0, go to IDLE.
  - busy is therefore high for exactly N cycles (T+1..T+N), and the new HI/LO are visible at T+N+1.
- MTHI/MTLO (op 5/6) in IDLE: HI (or LO) <= rs_val at the edge; single cycle; busy stays 0.
- Any md_op arriving while BUSY is ignored. The hazard unit guarantees this never happens; the bench checks it with an assertion.
- start is 0 whenever state == BUSY.
- MULT: signed 32x32 -> 64; HI = bits 63:32, LO = bits 31:0.
- MULTU: same split, unsigned operands.
- DIV: signed, quotient truncated toward zero; LO = quotient, HI = remainder, with the remainder taking the sign of the dividend.
- DIV of 0x80000000 by 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- DIVU: unsigned; LO = quotient, HI = remainder.
- Divisor == 0 (DIV/DIVU): the busy sequence still runs for DIV_CYCLES, but HI/LO are left unchanged at completion.
- rd_data reflects committed HI/LO only; pending results are never visible while busy.
- No bypass: an MFHI/MFLO stalled behind busy reads the committed value once busy drops.

Decomposition:
- md_op encodings (MD_NONE..MD_MTLO) go into head.v as shared `define constants, alongside the existing instruction codes.
- md_ctrl maps D/E instruction codes to md_op via those defines; that mapping lives in the decode path, not in this block.
- One natural sub-module: md_arith. It is purely combinational, takes op/rs_val/rt_val, and returns {hi, lo} plus a div_by_zero flag.
- md_ctrl keeps the FSM, counter, pending registers and HI/LO.

Test Plan:
- MULT, rs = 0xFFFFFFFE (-2), rt = 3 at edge T:
  - start = 1 in cycle T.
  - busy = 1 for cycles T+1..T+5.
  - At T+6: HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
- MULTU, rs = 0xFFFFFFFF, rt = 0xFFFFFFFF: after 5 busy cycles, HI = 0xFFFFFFFE, LO = 0x00000001.
- DIV, rs = 0xFFFFFFF9 (-7), rt = 2:
  - busy for 10 cycles.
  - Then LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFF (-1).
  - During busy, rd_data still shows the old values.
- DIVU, rs = 100, rt = 0, with HI = 0x11, LO = 0x22 beforehand: busy for 10 cycles; HI = 0x11 and LO = 0x22 remain unchanged.
- MTHI rs = 0xDEADBEEF, then MTLO rs = 0x12345678 in the next cycle:
  - busy stays 0 throughout.
  - rd_sel = 1 returns 0xDEADBEEF; rd_sel = 0 returns 0x12345678.
- MULT started, reset driven low asynchronously mid-cycle at the 3rd busy cycle:
  - busy = 0, HI = LO = 0 immediately.
  - After reset is released, a new DIVU 9/4 yields LO = 2, HI = 1 after 10 cycles.
